// File: rtl/wb_writer.sv
// Writeback arbiter: buffers ALU and LSU results in per-source FIFOs and retires at most
// one per cycle onto a registered, active-low-enable regfile write port.
module wb_writer #(
    parameter int DATA_W     = 64,
    parameter int IDX_W      = 5,
    parameter int BUF_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic [IDX_W-1:0]  alu_rd_i,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic [IDX_W-1:0]  lsu_rd_i,
    input  logic [DATA_W-1:0] lsu_data_i,
    output logic              rf_wen_n_o,
    output logic [IDX_W-1:0]  rf_rd_idx_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic              idle_o
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);
    localparam int ENT_W = IDX_W + DATA_W;

    // Source 0 is the ALU, source 1 is the LSU.
    logic [1:0]            in_valid;
    logic [1:0]            in_ready;
    logic [1:0]            head_vld;
    logic [1:0]            pop;
    logic [1:0][ENT_W-1:0] in_ent;
    logic [1:0][ENT_W-1:0] head_ent;

    assign in_valid  = {lsu_valid_i, alu_valid_i};
    assign in_ent[0] = {alu_rd_i, alu_data_i};
    assign in_ent[1] = {lsu_rd_i, lsu_data_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [ENT_W-1:0] mem_q [BUF_DEPTH];
            logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
            logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             push;

            // Readiness ignores a same-cycle pop so the accept path never depends on arbitration.
            assign in_ready[gi] = !rst && (cnt_q != CNT_W'(BUF_DEPTH));
            assign push         = in_valid[gi] & in_ready[gi];
            assign head_vld[gi] = (cnt_q != '0);
            assign head_ent[gi] = mem_q[rd_ptr_q];

            always_comb begin
                wr_ptr_d = wr_ptr_q + PTR_W'(push);
                rd_ptr_d = rd_ptr_q + PTR_W'(pop[gi]);
                cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop[gi]);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    cnt_q    <= cnt_d;
                end
            end

            always_ff @(posedge clk) begin
                if (push) begin
                    mem_q[wr_ptr_q] <= in_ent[gi];
                end
            end
        end
    endgenerate

    logic [ST_W-1:0]   starve_q, starve_d;
    logic              wen_n_q, wen_n_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              alu_win, lsu_win;
    logic [ENT_W-1:0]  win_ent;
    logic [IDX_W-1:0]  win_rd;
    logic [DATA_W-1:0] win_data;

    // LSU has priority; a starved ALU head takes the slot once its loss budget is spent.
    assign alu_win  = head_vld[0] & (~head_vld[1] | (starve_q == ST_W'(STARVE_MAX)));
    assign lsu_win  = head_vld[1] & ~alu_win;
    assign pop      = {lsu_win, alu_win};
    assign win_ent  = alu_win ? head_ent[0] : head_ent[1];
    assign win_rd   = win_ent[ENT_W-1 -: IDX_W];
    assign win_data = win_ent[DATA_W-1:0];

    always_comb begin
        starve_d = '0;
        wen_n_d  = 1'b1;
        idx_d    = idx_q;
        data_d   = data_q;
        if (head_vld[0] && !alu_win) begin
            starve_d = (starve_q == ST_W'(STARVE_MAX)) ? starve_q : starve_q + ST_W'(1);
        end
        // Writes to x0 are consumed silently and leave the presented index/data untouched.
        if ((alu_win || lsu_win) && (win_rd != '0)) begin
            wen_n_d = 1'b0;
            idx_d   = win_rd;
            data_d  = win_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            wen_n_q  <= 1'b1;
            idx_q    <= '0;
            data_q   <= '0;
        end else begin
            starve_q <= starve_d;
            wen_n_q  <= wen_n_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
        end
    end

    assign alu_ready_o = in_ready[0];
    assign lsu_ready_o = in_ready[1];
    assign rf_wen_n_o  = wen_n_q;
    assign rf_rd_idx_o = idx_q;
    assign rf_wdata_o  = data_q;
    assign idle_o      = ~head_vld[0] & ~head_vld[1] & wen_n_q;

endmodule

// File: tb/tb_wb_writer.sv
// Scoreboard bench for wb_writer: a queue-level reference model predicts each regfile write,
// and a negedge monitor compares what the DUT presents.
module tb_wb_writer;
    localparam int DATA_W = 64;
    localparam int IDX_W  = 5;
    localparam int DEPTH  = 2;
    localparam int SMAX   = 4;

    typedef logic [IDX_W+DATA_W-1:0] ent_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              alu_valid = 1'b0, lsu_valid = 1'b0;
    logic              alu_ready_o, lsu_ready_o;
    logic [IDX_W-1:0]  alu_rd = '0, lsu_rd = '0;
    logic [DATA_W-1:0] alu_data = '0, lsu_data = '0;
    logic              rf_wen_n_o, idle_o;
    logic [IDX_W-1:0]  rf_rd_idx_o;
    logic [DATA_W-1:0] rf_wdata_o;

    wb_writer #(.DATA_W(DATA_W), .IDX_W(IDX_W), .BUF_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid), .alu_ready_o(alu_ready_o), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data),
        .rf_wen_n_o(rf_wen_n_o), .rf_rd_idx_o(rf_rd_idx_o), .rf_wdata_o(rf_wdata_o), .idle_o(idle_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model state
    ent_t              alu_q[$];
    ent_t              lsu_q[$];
    ent_t              sb[$];
    int                alu_wait = 0;
    logic              exp_wen_n = 1'b1;
    logic [IDX_W-1:0]  exp_idx = '0;
    logic [DATA_W-1:0] exp_data = '0;
    bit                hold_known = 1'b1;
    logic [IDX_W-1:0]  wlog[$];

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    endtask

    task automatic model_step();
        ent_t e;
        bit   popped;
        bit   acc_a, acc_l;
        if (rst) begin
            alu_q.delete(); lsu_q.delete(); sb.delete();
            alu_wait = 0; exp_wen_n = 1'b1; exp_idx = '0; exp_data = '0; hold_known = 1'b1;
        end else begin
            acc_a  = alu_valid && (alu_q.size() < DEPTH);
            acc_l  = lsu_valid && (lsu_q.size() < DEPTH);
            popped = 1'b0;
            e      = '0;
            if (alu_q.size() > 0 && (lsu_q.size() == 0 || alu_wait >= SMAX)) begin
                e = alu_q.pop_front(); popped = 1'b1; alu_wait = 0;
            end else if (lsu_q.size() > 0) begin
                e = lsu_q.pop_front(); popped = 1'b1;
                alu_wait = (alu_q.size() > 0) ? ((alu_wait < SMAX) ? alu_wait + 1 : SMAX) : 0;
            end else begin
                alu_wait = 0;
            end
            exp_wen_n = 1'b1;
            if (popped) begin
                if (e[IDX_W+DATA_W-1:DATA_W] != '0) begin
                    exp_wen_n  = 1'b0;
                    exp_idx    = e[IDX_W+DATA_W-1:DATA_W];
                    exp_data   = e[DATA_W-1:0];
                    hold_known = 1'b1;
                    sb.push_back(e);
                end else begin
                    hold_known = 1'b0;
                end
            end
            if (acc_a) alu_q.push_back({alu_rd, alu_data});
            if (acc_l) lsu_q.push_back({lsu_rd, lsu_data});
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor
    initial begin
        ent_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("wen_n", rf_wen_n_o, exp_wen_n);
            check("alu_ready", alu_ready_o, (!rst && alu_q.size() < DEPTH));
            check("lsu_ready", lsu_ready_o, (!rst && lsu_q.size() < DEPTH));
            check("idle", idle_o, (alu_q.size() == 0 && lsu_q.size() == 0 && exp_wen_n));
            if (rf_wen_n_o === 1'b0) begin
                wlog.push_back(rf_rd_idx_o);
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: got idx %0h data %0h required no write at %0t",
                             rf_rd_idx_o, rf_wdata_o, $time);
                end else begin
                    e = sb.pop_front();
                    check("wr_idx", rf_rd_idx_o, e[IDX_W+DATA_W-1:DATA_W]);
                    check("wr_data", rf_wdata_o, e[DATA_W-1:0]);
                end
            end else if (hold_known) begin
                check("hold_idx", rf_rd_idx_o, exp_idx);
                check("hold_data", rf_wdata_o, exp_data);
            end
            sb.delete();
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  n;
        int  pos;
        bit  alu_full_seen;
        bit  acc_a, acc_l;
        int  p_alu, p_lsu;

        // Reset for two edges
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        repeat (2) cyc();

        // Single ALU write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        cyc();
        alu_valid = 1'b0;
        repeat (4) cyc();

        // LSU write to x0 is swallowed
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'hDEAD;
        cyc();
        lsu_valid = 1'b0;
        repeat (4) cyc();

        // Simultaneous arrivals: LSU first
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'hA;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 64'hB;
        cyc();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        repeat (4) cyc();

        // Starvation limit: four LSU writes, then the ALU entry
        wlog.delete();
        n = 0;
        for (int i = 0; i < 16; i++) begin
            lsu_valid = 1'b1; lsu_rd = 5'(8 + n % 20); lsu_data = 64'h100 + 64'(n);
            alu_valid = (i == 0); alu_rd = 5'd7; alu_data = 64'h77;
            acc_l = lsu_ready_o;
            cyc();
            if (acc_l) n++;
        end
        lsu_valid = 1'b0; alu_valid = 1'b0;
        repeat (4) cyc();
        pos = -1;
        for (int i = 0; i < wlog.size(); i++) begin
            if (pos < 0 && wlog[i] == 5'd7) pos = i;
        end
        check("starve_slot", 64'(pos), 64'd4);

        // Fill the ALU FIFO behind a busy LSU, then reset mid-stream
        alu_full_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            lsu_valid = 1'b1; lsu_rd = 5'(8 + n % 20); lsu_data = 64'h200 + 64'(n);
            alu_valid = (i < 2); alu_rd = 5'(20 + i); alu_data = 64'h300 + 64'(i);
            acc_l = lsu_ready_o;
            cyc();
            if (acc_l) n++;
            if (!alu_ready_o) alu_full_seen = 1'b1;
        end
        check("alu_full_seen", 64'(alu_full_seen), 64'd1);
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0; lsu_valid = 1'b0; alu_valid = 1'b0;
        cyc();
        check("idle_after_rst", idle_o, 1'b1);
        check("wen_after_rst", rf_wen_n_o, 1'b1);
        repeat (2) cyc();

        // Randomized traffic with held offers
        for (int i = 0; i < 400; i++) begin
            case (i / 100)
                0: begin p_alu = 60; p_lsu = 90; end
                1: begin p_alu = 90; p_lsu = 40; end
                2: begin p_alu = 30; p_lsu = 20; end
                default: begin p_alu = 95; p_lsu = 95; end
            endcase
            if (i == 250) rst = 1'b1;
            if (i == 251) rst = 1'b0;
            acc_a = alu_valid && alu_ready_o;
            acc_l = lsu_valid && lsu_ready_o;
            if (!alu_valid || acc_a || rst) begin
                alu_valid = ($urandom_range(0, 99) < p_alu);
                alu_rd    = 5'($urandom_range(0, 31));
                alu_data  = {$urandom, $urandom};
            end
            if (!lsu_valid || acc_l || rst) begin
                lsu_valid = ($urandom_range(0, 99) < p_lsu);
                lsu_rd    = 5'($urandom_range(0, 31));
                lsu_data  = {$urandom, $urandom};
            end
            cyc();
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        repeat (12) cyc();
        check("drained", 64'(alu_q.size() + lsu_q.size()), 64'd0);
        check("idle_end", idle_o, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
